// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_STEP     = 4;
  localparam int unsigned BUF_ENTRIES = 2;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fetch buffer; slot 0 is always the head so the head output is a
// plain register. Flush beats push and pop.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic [1:0]    count
);

  localparam logic [1:0] FULL = 2'(BUF_ENTRIES);

  logic [BUF_ENTRIES-1:0][DW-1:0] slot_reg;
  logic [BUF_ENTRIES-1:0][DW-1:0] slot_next;
  logic [1:0]                     count_reg;
  logic [1:0]                     count_next;
  logic [1:0]                     wr_idx;
  logic                           pop_ok;
  logic                           push_ok;

  assign pop_ok  = pop && (count_reg != 2'd0) && !flush;
  assign push_ok = push && !flush && ((count_reg < FULL) || pop_ok);
  // A simultaneous pop shifts everything down one slot before the write lands.
  assign wr_idx  = count_reg - {1'b0, pop_ok};

  for (genvar gi = 0; gi < BUF_ENTRIES; gi++) begin : g_slot
    if (gi < BUF_ENTRIES - 1) begin : g_mid
      assign slot_next[gi] = (push_ok && wr_idx == 2'(gi)) ? din :
                             pop_ok ? slot_reg[gi+1] : slot_reg[gi];
    end else begin : g_tail
      assign slot_next[gi] = (push_ok && wr_idx == 2'(gi)) ? din : slot_reg[gi];
    end
  end

  assign count_next = flush ? 2'd0 : (count_reg + {1'b0, push_ok} - {1'b0, pop_ok});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg  <= '0;
      count_reg <= 2'd0;
    end else begin
      slot_reg  <= slot_next;
      count_reg <= count_next;
    end
  end

  assign head  = slot_reg[0];
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the combinational instruction
// memory and hands {pc, instr} pairs to decode through a 2-entry buffer.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 256,
  parameter int              BITS     = 32,
  parameter int              WIDTH    = 32,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             redirect_valid,
  input  logic [BITS-1:0]  redirect_pc,
  output logic [BITS-1:0]  imem_adr,
  input  logic [WIDTH-1:0] imem_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [BITS-1:0]  out_pc,
  output logic             busy,
  output logic             misalign_err
);

  localparam logic [BITS-1:0] PC_MASK = BITS'(DEPTH * PC_STEP - 1);
  localparam logic [1:0]      FULL    = 2'(BUF_ENTRIES);

  fetch_state_t    state_reg;
  logic            busy_reg;
  logic [BITS-1:0] pc_reg;
  logic            misalign_reg;

  logic            push;
  logic            pop;
  logic [1:0]      buf_count;
  logic [BITS+WIDTH-1:0] buf_head;

  assign pop  = (buf_count != 2'd0) && out_ready && !redirect_valid;
  assign push = (state_reg == RUN) && !redirect_valid && !halt_req &&
                ((buf_count < FULL) || pop);

  fetch_buf #(
    .DW(BITS + WIDTH)
  ) u_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  ({pc_reg, imem_dout}),
    .head (buf_head),
    .count(buf_count)
  );

  // halt_req wins over start; a redirect never blocks a state change by itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, HALT: begin
          if (start && !halt_req) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          if (halt_req) begin
            state_reg <= HALT;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // PC stays inside the memory span; the low two bits are always zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC & PC_MASK;
      misalign_reg <= 1'b0;
    end else if (redirect_valid) begin
      pc_reg <= {redirect_pc[BITS-1:2], 2'b00} & PC_MASK;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_reg <= 1'b1;
      end
    end else if (push) begin
      pc_reg <= (pc_reg + BITS'(PC_STEP)) & PC_MASK;
    end
  end

  assign imem_adr            = pc_reg;
  assign out_valid           = (buf_count != 2'd0);
  assign {out_pc, out_instr} = buf_head;
  assign busy                = busy_reg;
  assign misalign_err        = misalign_reg;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl; memory word i holds 32'hA000_0000 | i.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_adr;
  logic [31:0] imem_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;
  logic        misalign_err;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_dout = mem[imem_adr >> 2];

  instr_fetch_ctrl #(
    .DEPTH(256), .BITS(32), .WIDTH(32), .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .halt_req      (halt_req),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_adr      (imem_adr),
    .imem_dout     (imem_dout),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .busy          (busy),
    .misalign_err  (misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_instr"}, out_instr, instr);
    $display("head %s pc=%h instr=%h", tag, out_pc, out_instr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_pc"}, out_pc, 32'h0);
    check({tag, "_instr"}, out_instr, 32'h0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_adr"}, imem_adr, 32'h0);
    $display("reset state %s checked", tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;

    // Reset values
    tick();
    check_reset_outputs("rst");
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    rst_n = 1'b1;

    // Streaming after start
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_first_nvalid", {31'd0, out_valid}, 32'd0);
    check("t1_first_adr", imem_adr, 32'h0);
    tick();
    check_head("t1_0", 32'h0, 32'hA000_0000);
    tick();
    check_head("t1_1", 32'h4, 32'hA000_0001);
    tick();
    check_head("t1_2", 32'h8, 32'hA000_0002);
    tick();
    check_head("t1_3", 32'hC, 32'hA000_0003);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    rst_n = 1'b1;

    // Backpressure
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("bp_adr1", imem_adr, 32'h4);
    tick();
    check("bp_adr2", imem_adr, 32'h8);
    tick();
    check("bp_adr3", imem_adr, 32'h8);
    tick();
    check("bp_adr4", imem_adr, 32'h8);
    check_head("bp_hold", 32'h0, 32'hA000_0000);
    out_ready = 1'b1;
    tick();
    check_head("bp_r1", 32'h4, 32'hA000_0001);
    tick();
    check_head("bp_r2", 32'h8, 32'hA000_0002);
    tick();
    check_head("bp_r3", 32'hC, 32'hA000_0003);

    // Redirect with a full buffer
    out_ready = 1'b0;
    tick();
    check_head("rd_full", 32'hC, 32'hA000_0003);
    check("rd_full_adr", imem_adr, 32'h14);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1;
    check("rd_nvalid", {31'd0, out_valid}, 32'd0);
    check("rd_adr", imem_adr, 32'h40);
    tick();
    check_head("rd_0", 32'h40, 32'hA000_0010);
    tick();
    check_head("rd_1", 32'h44, 32'hA000_0011);
    check("rd_misalign", {31'd0, misalign_err}, 32'd0);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick();
    redirect_valid = 1'b0;
    check("mis_nvalid", {31'd0, out_valid}, 32'd0);
    check("mis_adr", imem_adr, 32'h40);
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    tick();
    check_head("mis_0", 32'h40, 32'hA000_0010);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("mis_sticky", {31'd0, misalign_err}, 32'd1);
    check("mis_adr2", imem_adr, 32'h100);

    // Wrap at the top of memory
    redirect_valid = 1'b1; redirect_pc = 32'h3FC;
    tick();
    redirect_valid = 1'b0;
    check("wr_adr", imem_adr, 32'h3FC);
    tick();
    check_head("wr_0", 32'h3FC, 32'hA000_00FF);
    check("wr_adr0", imem_adr, 32'h0);
    tick();
    check_head("wr_1", 32'h0, 32'hA000_0000);
    tick();
    check_head("wr_2", 32'h4, 32'hA000_0001);
    check("wr_sticky", {31'd0, misalign_err}, 32'd1);

    // Halt with two entries buffered
    out_ready = 1'b0;
    tick();
    tick();
    check_head("h_full", 32'h4, 32'hA000_0001);
    check("h_full_adr", imem_adr, 32'hC);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("h_busy", {31'd0, busy}, 32'd0);
    check_head("h_d0", 32'h4, 32'hA000_0001);
    check("h_adr_hold", imem_adr, 32'hC);
    out_ready = 1'b1;
    tick();
    check_head("h_d1", 32'h8, 32'hA000_0002);
    tick();
    check("h_empty", {31'd0, out_valid}, 32'd0);
    check("h_adr_hold2", imem_adr, 32'hC);
    tick();
    check("h_empty2", {31'd0, out_valid}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("h_resume_busy", {31'd0, busy}, 32'd1);
    tick();
    check_head("h_resume", 32'hC, 32'hA000_0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
